// File: rtl/vote_input_conditioner.sv
// Front end for the voting FSM: synchronises and debounces the candidate buttons and the
// voting-over switch, then turns each accepted press into one fixed-width vote pulse.
module vote_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES  = 32,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_1,
  input  logic       i_btn_2,
  input  logic       i_btn_3,
  input  logic       i_btn_over,
  input  logic       i_enable,
  output logic       o_candidate_1,
  output logic       o_candidate_2,
  output logic       o_candidate_3,
  output logic       o_voting_over,
  output logic [1:0] o_vote_id,
  output logic       o_busy,
  output logic       o_reject
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT, WAIT_RELEASE} state_t;

  logic [3:0]       raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       deb;
  logic [2:0]       deb_btn;
  logic [2:0]       deb_prev;
  logic [2:0]       press;
  logic             single_high;
  logic             accept_ok;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       cand;
  logic [1:0]       vote_id;
  logic             busy;
  logic             reject;
  logic             voting_over;

  assign raw = {i_btn_over, i_btn_3, i_btn_2, i_btn_1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // A debounced state only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_b[g] != level) begin
        if (cnt == DB_LAST) begin
          level <= sync_b[g];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[g] = level;
  end

  assign deb_btn     = deb[2:0];
  assign press       = deb_btn & ~deb_prev;
  assign single_high = ((deb_btn & (deb_btn - 3'd1)) == 3'd0);
  assign accept_ok   = i_enable && !voting_over;

  // A press only counts when it is the sole button held; anything else is rejected outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev    <= '0;
      voting_over <= 1'b0;
      state       <= IDLE;
      timer       <= '0;
      cand        <= '0;
      vote_id     <= '0;
      busy        <= 1'b0;
      reject      <= 1'b0;
    end else begin
      deb_prev    <= deb_btn;
      voting_over <= deb[3];
      reject      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ok && (press != 3'd0)) begin
            timer <= '0;
            busy  <= 1'b1;
            if (single_high) begin
              state   <= PULSE;
              cand    <= press;
              vote_id <= {press[2] | press[1], press[2] | press[0]};
            end else begin
              state  <= WAIT_RELEASE;
              reject <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (timer == PULSE_LAST) begin
            state   <= LOCKOUT;
            timer   <= '0;
            cand    <= '0;
            vote_id <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state <= WAIT_RELEASE;
            timer <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        WAIT_RELEASE: begin
          if (deb_btn == 3'd0) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_candidate_1 = cand[0];
  assign o_candidate_2 = cand[1];
  assign o_candidate_3 = cand[2];
  assign o_vote_id     = vote_id;
  assign o_busy        = busy;
  assign o_reject      = reject;
  assign o_voting_over = voting_over;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner: every expected vote pulse is queued when its
// press is driven and matched against the pulse the design actually produces.
module tb_vote_input_conditioner;

  localparam int LAT = 19;

  typedef struct {
    int id;
    int rise;
    int width;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_1, btn_2, btn_3, btn_over, enable;
  logic       cand_1, cand_2, cand_3, voting_over, busy, reject;
  logic [1:0] vote_id;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rej_seen = 0;
  int         width = 0;
  logic       active = 1'b0;
  logic [2:0] prev_cand = 3'd0;
  logic [2:0] mon_cand;
  exp_t       sb[$];
  exp_t       cur;

  vote_input_conditioner dut (
    .clk(clk),
    .rst(rst),
    .i_btn_1(btn_1),
    .i_btn_2(btn_2),
    .i_btn_3(btn_3),
    .i_btn_over(btn_over),
    .i_enable(enable),
    .o_candidate_1(cand_1),
    .o_candidate_2(cand_2),
    .o_candidate_3(cand_3),
    .o_voting_over(voting_over),
    .o_vote_id(vote_id),
    .o_busy(busy),
    .o_reject(reject)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int cand_id(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic apply_stimulus(input logic [3:0] b);
    {btn_over, btn_3, btn_2, btn_1} = b;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int id, input int w);
    sb.push_back('{id, cyc + LAT, w});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("idle_reached", busy, 0);
  endtask

  // Pulse monitor: pops the scoreboard on each rising pulse and checks its width on the fall.
  always @(negedge clk) begin
    mon_cand = {cand_3, cand_2, cand_1};
    if ((mon_cand & ~prev_cand) != 3'd0) begin
      check_output("pulse_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        check_output("pulse_id", cand_id(mon_cand), cur.id);
        check_output("pulse_rise_cycle", cyc, cur.rise);
        check_output("pulse_vote_id", vote_id, cur.id);
        active = 1'b1;
        width  = 1;
      end
    end else if (mon_cand != 3'd0 && active) begin
      width++;
    end
    if (mon_cand == 3'd0 && prev_cand != 3'd0 && active) begin
      check_output("pulse_width", width, cur.width);
      check_output("vote_id_cleared", vote_id, 0);
      active = 1'b0;
    end
    if (reject === 1'b1) rej_seen++;
    prev_cand = mon_cand;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    enable = 1'b1;
    apply_stimulus(4'b0000);
    #3;
    check_output("rst_cand_1", cand_1, 0);
    check_output("rst_cand_2", cand_2, 0);
    check_output("rst_cand_3", cand_3, 0);
    check_output("rst_vote_id", vote_id, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_reject", reject, 0);
    check_output("rst_voting_over", voting_over, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);

    // Clean press of button 2, busy held until the release has been debounced
    apply_stimulus(4'b0010);
    expect_pulse(2, 4);
    wait_cycles(100);
    apply_stimulus(4'b0000);
    check_output("busy_while_held", busy, 1);
    wait_cycles(18);
    check_output("busy_before_release_seen", busy, 1);
    wait_cycles(1);
    check_output("idle_after_release", busy, 0);
    wait_cycles(5);

    // Bouncing button 1 never reaches the debounce threshold
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(4'b0001);
      wait_cycles(10);
      apply_stimulus(4'b0000);
      wait_cycles(10);
      check_output("bounce_busy", busy, 0);
    end
    apply_stimulus(4'b0001);
    expect_pulse(1, 4);
    wait_cycles(30);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);

    // Buttons 1 and 3 together are rejected
    apply_stimulus(4'b0101);
    wait_cycles(19);
    check_output("reject_pulse", reject, 1);
    wait_cycles(1);
    check_output("reject_one_cycle", reject, 0);
    check_output("busy_after_reject", busy, 1);
    wait_cycles(20);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);
    check_output("reject_count_once", rej_seen, 1);
    apply_stimulus(4'b0100);
    expect_pulse(3, 4);
    wait_cycles(25);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);

    // Button 2 pressed during lockout while button 1 still held gives no vote
    apply_stimulus(4'b0001);
    expect_pulse(1, 4);
    wait_cycles(30);
    apply_stimulus(4'b0011);
    wait_cycles(40);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);
    apply_stimulus(4'b0010);
    expect_pulse(2, 4);
    wait_cycles(25);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);

    // Voting-over blocks presses until it is debounced low again
    apply_stimulus(4'b1000);
    wait_cycles(18);
    check_output("over_not_yet", voting_over, 0);
    wait_cycles(1);
    check_output("over_rises", voting_over, 1);
    apply_stimulus(4'b1100);
    wait_cycles(1);
    apply_stimulus(4'b0100);
    wait_cycles(40);
    apply_stimulus(4'b0000);
    wait_cycles(25);
    check_output("over_blocked_busy", busy, 0);
    check_output("over_falls", voting_over, 0);
    wait_cycles(5);
    apply_stimulus(4'b0100);
    expect_pulse(3, 4);
    wait_cycles(25);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);

    // Press held while disabled produces nothing when enable rises
    enable = 1'b0;
    apply_stimulus(4'b0001);
    wait_cycles(30);
    check_output("disabled_busy", busy, 0);
    enable = 1'b1;
    wait_cycles(10);
    check_output("enable_rise_no_vote", busy, 0);
    apply_stimulus(4'b0000);
    wait_cycles(25);
    check_output("disabled_no_pending", sb.size(), 0);

    // Reset in the second cycle of a pulse, button still held afterwards
    apply_stimulus(4'b0001);
    expect_pulse(1, 2);
    n = 0;
    while (cand_1 !== 1'b1 && n < 40) begin
      wait_cycles(1);
      n++;
    end
    check_output("pulse_started", cand_1, 1);
    wait_cycles(1);
    #1 rst = 1'b0;
    #1;
    check_output("midrst_cand_1", cand_1, 0);
    check_output("midrst_cand_2", cand_2, 0);
    check_output("midrst_cand_3", cand_3, 0);
    check_output("midrst_vote_id", vote_id, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_reject", reject, 0);
    wait_cycles(2);
    rst = 1'b1;
    expect_pulse(1, 4);
    wait_cycles(30);
    apply_stimulus(4'b0000);
    wait_idle(200);
    wait_cycles(5);

    check_output("sb_drained", sb.size(), 0);
    check_output("reject_count_final", rej_seen, 1);
    check_output("no_open_pulse", active, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_input_conditioner.md
Name: vote_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the voting FSM and drives its candidate and voting-over inputs.
- Synchronises and debounces three raw candidate buttons and the voting-over switch.
- Arbitrates so that each physical press yields at most one clean, fixed-width active-high pulse. The downstream FSM counts on that pulse's falling edge.
- Rejects multi-button presses and enforces a lockout between votes.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronised samples a raw input must differ from its debounced state before that state flips (>=1).
- PULSE_CYCLES, 4, cycles each accepted vote pulse is held high (>=1).
- LOCKOUT_CYCLES, 32, cycles after a pulse during which all presses are ignored (>=1).
- CNT_W, 8, width of the shared timer and each debounce counter. Must hold max(DEBOUNCE_CYCLES, PULSE_CYCLES, LOCKOUT_CYCLES)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- i_btn_1  input  1  raw candidate-1 button, asynchronous, active-high
- i_btn_2  input  1  raw candidate-2 button, asynchronous, active-high
- i_btn_3  input  1  raw candidate-3 button, asynchronous, active-high
- i_btn_over  input  1  raw voting-over switch, asynchronous, active-high
- i_enable  input  1  synchronous, 1 = new votes may be accepted
- o_candidate_1  output  1  clean vote pulse for candidate 1
- o_candidate_2  output  1  clean vote pulse for candidate 2
- o_candidate_3  output  1  clean vote pulse for candidate 3
- o_voting_over  output  1  debounced voting-over level
- o_vote_id  output  2  0 = none, 1..3 = candidate being pulsed; valid while a pulse is high
- o_busy  output  1  high whenever FSM is not in IDLE
- o_reject  output  1  one-cycle pulse when a multi-button press is rejected

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, all synchroniser flops 0, debounced states 0, counters 0, FSM to IDLE.
- Synchroniser: two flops per raw input, giving 2 cycles of latency.
- Debounce, per input:
  - If the synchronised value differs from the debounced state, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced state takes the synchronised value and the counter clears.
  - If the values are equal, the counter clears.
  - A press event is a cycle in which a button's debounced state rises 0->1.
- FSM states: IDLE, PULSE, LOCKOUT, WAIT_RELEASE.
- IDLE, with i_enable=1 and o_voting_over=0:
  - Exactly one press event and no other debounced button high: latch its id, go to PULSE. The matching o_candidate_k and o_vote_id become valid on the next edge.
  - Press event together with any other debounced button high, or two or more simultaneous events: o_reject=1 for one cycle, go to WAIT_RELEASE.
  - With i_enable=0 or o_voting_over=1: press events are ignored and the FSM stays in IDLE. A button held when enable rises produces no vote, because there is no edge.
- PULSE:
  - o_candidate_k is high for exactly PULSE_CYCLES cycles, then drops. Its falling edge is the vote seen downstream.
  - FSM then goes to LOCKOUT and o_vote_id returns to 0.
  - A pulse already started always completes, even if o_voting_over or i_enable changes.
- LOCKOUT: counts LOCKOUT_CYCLES cycles while ignoring all buttons, then goes to WAIT_RELEASE.
- WAIT_RELEASE: returns to IDLE on the first cycle in which all three debounced buttons are 0. If they are already 0, that takes one cycle.
- o_voting_over: the debounced i_btn_over level, with no FSM gating. Latency is 2+DEBOUNCE_CYCLES cycles.
- Exclusivity: at most one o_candidate_k is high in any cycle. All o_candidate outputs are registered and glitch-free.
- Shared timer: cleared on every state entry, so no wrap-around is possible within its range.
- Reset mid-pulse: the pulse aborts with its output forced to 0. No falling edge may be produced except by reset.
- Button held through reset: debounced state restarts at 0, so it registers one press event after 2+DEBOUNCE_CYCLES cycles.
- End-to-end latency with defaults: o_candidate_k rises 18 cycles after the edge that first samples the raw button high.

Test Plan:
- Clean press, defaults: i_btn_2 high for 100 cycles -> o_candidate_2 rises 18 cycles after first sample, high 4 cycles, o_vote_id=2 during pulse. o_busy stays high until 32 lockout cycles end and the button has been debounced low.
- Bounce: i_btn_1 toggling with high runs of 10 cycles for 200 cycles -> no o_candidate pulse, o_busy stays 0. Then a 30-cycle clean hold -> exactly one pulse.
- Simultaneous: i_btn_1 and i_btn_3 rise on the same cycle, held 40 cycles -> o_reject pulses once, no o_candidate pulse. After release, a single i_btn_3 press -> one pulse on o_candidate_3.
- Overlap: i_btn_1 accepted, then i_btn_2 pressed during lockout while i_btn_1 still held -> no second pulse until both are released and i_btn_2 is pressed again.
- Voting over: i_btn_over high 20 cycles -> o_voting_over rises after 18 cycles. A subsequent i_btn_3 press gives no pulse. i_btn_over released and debounced -> i_btn_3 press accepted.
- Reset mid-pulse: rst low on cycle 2 of a candidate-1 pulse -> o_candidate_1 and all outputs 0 immediately. After rst high with the button still held -> one new pulse 18 cycles later.
